// File: rtl/debouncer_bank.sv
// debouncer_bank: N_CH independent switch debouncers sharing one sample tick.
// Each channel flips its output after STABLE_TICKS consecutive ticks of opposite input.
module debouncer_bank #(
    parameter int              N_CH         = 4,
    parameter int              TICK_BITS    = 19,
    parameter int              STABLE_TICKS = 3,
    parameter logic [N_CH-1:0] INVERT_MASK  = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_change
);

    localparam int            CW   = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [N_CH-1:0]      sync1;
    logic [N_CH-1:0]      sync2;
    logic [N_CH-1:0]      s;
    logic [TICK_BITS-1:0] tick_cnt;
    logic                 tick;
    logic [CW-1:0]        cnt     [N_CH];
    logic [CW-1:0]        cnt_nxt [N_CH];
    logic [N_CH-1:0]      toggle;

    assign s    = sync2 ^ INVERT_MASK;
    assign tick = (tick_cnt == {TICK_BITS{1'b1}});

    // Any sample matching db throws away accumulated credit.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s[i] == db[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt[i] == LAST) begin
                    toggle[i]  = 1'b1;
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            tick_cnt   <= '0;
            db         <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= sw;
            sync2      <= sync1;
            tick_cnt   <= tick_cnt + TICK_BITS'(1);
            db         <= db ^ toggle;
            rise_pulse <= toggle & ~db;
            fall_pulse <= toggle & db;
            any_change <= |toggle;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: doc/debouncer_bank.md
DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent switch channels (>=1).
REQ-002 The block SHALL have parameter TICK_BITS, default 19: sample tick period P = 2^TICK_BITS clk cycles (>=1).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 3: ticks of stable opposite level needed to flip an output (>=1).
REQ-004 The block SHALL have parameter INVERT_MASK, default {N_CH{1'b0}}: per-channel input inversion for active-low switches.
REQ-005 The block SHALL have port clk, input, 1: single clock for all logic.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port sw, input, N_CH: raw asynchronous switch levels.
REQ-008 The block SHALL have port db, output, N_CH: debounced active-high levels.
REQ-009 The block SHALL have port rise_pulse, output, N_CH: one-cycle strobe on db 0->1.
REQ-010 The block SHALL have port fall_pulse, output, N_CH: one-cycle strobe on db 1->0.
REQ-011 The block SHALL have port any_change, output, 1: OR of all rise_pulse and fall_pulse bits.

Function
REQ-012 Each sw bit SHALL pass through a 2-FF synchronizer, then XOR with INVERT_MASK bit, giving s[i] usable 2 cycles after sw changes.
REQ-013 One shared free-running TICK_BITS-wide counter SHALL wrap modulo P; tick SHALL be high exactly in cycles where counter == P-1.
REQ-014 Each channel SHALL hold a stable-count register of width clog2(STABLE_TICKS+1), saturating never above STABLE_TICKS-1.
REQ-015 Per channel each cycle: s[i] == db[i] -> count cleared to 0, db held.
REQ-016 s[i] != db[i], tick low -> count and db held.
REQ-017 s[i] != db[i], tick high, count < STABLE_TICKS-1 -> count incremented.
REQ-018 s[i] != db[i], tick high, count == STABLE_TICKS-1 -> db[i] toggled at that edge, count cleared.
REQ-019 Latency SHALL be sw edge to db edge in [2+(STABLE_TICKS-1)*P, 2+STABLE_TICKS*P-1] cycles; input pulses shorter than 2+(STABLE_TICKS-1)*P are never passed.
REQ-020 Any reversion of s[i] to db[i] before the final tick SHALL fully discard accumulated count (no partial credit).
REQ-021 rise_pulse[i]/fall_pulse[i] SHALL be registered, high for exactly the first cycle db[i] shows its new value, never both high.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce same-cycle outputs and pulses on each.
REQ-023 db, pulses and any_change SHALL be registered outputs with no combinational path from sw.

Reset
REQ-024 With reset high at a clk edge, synchronizers, tick counter, all counts, db, rise_pulse, fall_pulse, any_change SHALL be 0 after that edge.
REQ-025 Reset SHALL override all other activity, including a toggle scheduled for the same edge; no pulse SHALL be emitted on or after reset due to it.
REQ-026 After release, a channel whose s[i]=1 SHALL re-qualify from count 0 under REQ-015..REQ-019 and then emit rise_pulse.

Verification (N_CH=4, TICK_BITS=2 (P=4), STABLE_TICKS=3, INVERT_MASK=4'b0001 unless stated)
REQ-027 Clean press: sw[1] 0->1 held -> db[1] rises 10..13 cycles later, rise_pulse[1] and any_change high that one cycle only; release likewise -> fall_pulse[1].
REQ-028 Glitch: sw[1] high for 5 cycles then low -> db[1] stays 0, no pulses; bounce 1,0,1 at 3-cycle spacing then held -> db[1] rises 10..13 cycles after last edge.
REQ-029 Simultaneous: sw[2], sw[3] rise same cycle -> db[3:2] go 2'b11 same cycle, rise_pulse[3:2]=2'b11 one cycle.
REQ-030 Reset mid-operation: db[1]=1, sw[1] low with count=1, reset pulsed 1 cycle -> all outputs 0 next cycle, no fall_pulse; sw[1] later held 1 -> db[1] rises 10..13 cycles after reset release with rise_pulse[1].
REQ-031 Inversion: sw[0]=1 through reset -> db[0]=0 indefinitely; sw[0] 1->0 held -> db[0] rises 10..13 cycles later with rise_pulse[0].
REQ-032 Tick alignment: counter == P-1 observed every 4th cycle, first at cycle 3 after reset release.
